// File: rtl/store_check_monitor.sv
// Self-check monitor on the CPU data-memory write port: compares each store against an
// ordered table of expected stores and reports PASS / FAIL / TMO plus match/error counts.
module store_check_monitor #(
  parameter int DEPTH        = 8,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MATCH_ADDR   = 1,
  parameter int STOP_ON_FAIL = 1,
  parameter int TIMEOUT      = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [DW-1:0]            cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_num,
  input  logic                     start,
  input  logic                     memwrite,
  input  logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [7:0]               match_cnt,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [DW-1:0]            fail_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT);
  localparam logic [IW:0]   NUM_MAX  = (IW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW:0]     num_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      match_q;
  logic [7:0]      err_q;
  logic [IW-1:0]   fail_idx_q;
  logic [DW-1:0]   fail_data_q;

  logic [AW-1:0]   tab_addr_q [DEPTH];
  logic [DW-1:0]   tab_data_q [DEPTH];

  logic            addr_ok;
  logic            cur_match;
  logic            is_last;
  logic [IW:0]     num_clamped;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Table is deliberately outside the reset domain so expected stores survive a reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cfg_we) begin
      tab_addr_q[cfg_idx] <= cfg_addr;
      tab_data_q[cfg_idx] <= cfg_data;
    end
  end

  assign addr_ok     = (MATCH_ADDR == 0) ? 1'b1 : (tab_addr_q[ptr_q] == mem_addr);
  assign cur_match   = addr_ok && (tab_data_q[ptr_q] == mem_wdata);
  assign is_last     = ({1'b0, ptr_q} == (num_q - (IW+1)'(1)));
  assign num_clamped = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      num_q       <= '0;
      timer_q     <= '0;
      match_q     <= '0;
      err_q       <= '0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
    end else if (start) begin
      num_q       <= num_clamped;
      ptr_q       <= '0;
      timer_q     <= '0;
      match_q     <= '0;
      err_q       <= '0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
      state_q     <= (cfg_num == '0) ? S_PASS : S_RUN;
    end else if (state_q == S_RUN) begin
      if (memwrite) begin
        timer_q <= '0;
        // Hold the pointer on the last entry; the run leaves RUN on this edge anyway.
        if (!is_last) ptr_q <= ptr_q + IW'(1);
        if (cur_match) begin
          match_q <= sat_inc(match_q);
        end else begin
          err_q <= sat_inc(err_q);
          if (err_q == 8'd0) begin
            fail_idx_q  <= ptr_q;
            fail_data_q <= mem_wdata;
          end
        end
        if (!cur_match && STOP_ON_FAIL != 0) begin
          state_q <= S_FAIL;
        end else if (is_last) begin
          state_q <= (err_q == 8'd0 && cur_match) ? S_PASS : S_FAIL;
        end
      end else begin
        if (timer_q == TMR_LAST) state_q <= S_TMO;
        if (timer_q < TMR_MAX) timer_q <= timer_q + TW'(1);
      end
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TMO);
  assign pass      = (state_q == S_PASS);
  assign timeout   = (state_q == S_TMO);
  assign match_cnt = match_q;
  assign err_cnt   = err_q;
  assign fail_idx  = fail_idx_q;
  assign fail_data = fail_data_q;

endmodule
